// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding a sequence detector: one-word holding register
// in front of a shift register with a per-bit period divider and selectable bit order.
module seq_bit_serializer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DIV_W  = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Din,
    input  logic              Din_vld,
    output logic              Din_rdy,
    input  logic              Msb_first,
    input  logic [DIV_W-1:0]  Div,
    output logic              Sout,
    output logic              Bit_stb,
    output logic              Word_done,
    output logic              Busy
);

    localparam int unsigned CntW = $clog2(DATA_W);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]  period_q, period_d;
    logic              msb_q, msb_d;

    logic            bit_stb;
    logic            last_bit;
    logic            accept;
    logic            load;
    logic [CntW-1:0] bit_idx;

    assign bit_stb  = (state_q == StShift) && (div_cnt_q == '0);
    assign last_bit = (bit_cnt_q == LastBit);
    assign accept   = Din_vld && !hold_full_q;
    // Reload straight from the last strobe so consecutive words run without a gap.
    assign load     = hold_full_q && ((state_q == StIdle) || (bit_stb && last_bit));
    assign bit_idx  = msb_q ? (LastBit - bit_cnt_q) : bit_cnt_q;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        period_d    = period_q;
        msb_d       = msb_q;

        if (accept) begin
            hold_d      = Din;
            hold_full_d = 1'b1;
        end

        if (load) begin
            hold_full_d = 1'b0;
            shift_d     = hold_q;
            msb_d       = Msb_first;
            period_d    = Div;
            bit_cnt_d   = '0;
            div_cnt_d   = Div;
            state_d     = StShift;
        end else if (state_q == StShift) begin
            if (bit_stb) begin
                if (last_bit) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    div_cnt_d = period_q;
                end
            end else begin
                div_cnt_d = div_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            period_q    <= '0;
            msb_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            period_q    <= period_d;
            msb_q       <= msb_d;
        end
    end

    // Outputs decode registers only, so reset forces them without waiting for a clock.
    assign Din_rdy   = !hold_full_q;
    assign Sout      = (state_q == StShift) && shift_q[bit_idx];
    assign Bit_stb   = bit_stb;
    assign Word_done = bit_stb && last_bit;
    assign Busy      = (state_q == StShift) || hold_full_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Scoreboard bench for seq_bit_serializer: stimulus queues expected bits, a negedge
// monitor checks every strobe for bit value, end-of-word flag and spacing.
module tb_seq_bit_serializer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic [7:0] Din = '0;
    logic       Din_vld = 1'b0;
    logic       Din_rdy;
    logic       Msb_first = 1'b1;
    logic [3:0] Div = '0;
    logic       Sout;
    logic       Bit_stb;
    logic       Word_done;
    logic       Busy;

    seq_bit_serializer #(
        .DATA_W(8),
        .DIV_W (4)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Din      (Din),
        .Din_vld  (Din_vld),
        .Din_rdy  (Din_rdy),
        .Msb_first(Msb_first),
        .Div      (Div),
        .Sout     (Sout),
        .Bit_stb  (Bit_stb),
        .Word_done(Word_done),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic b;
        logic last;
        int   gap;  // expected cycles since previous strobe; 0 = unchecked
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_stb = 0;
    int   n_wd = 0;
    int   cyc_since = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [7:0] d, input logic msb, input int first_gap,
                             input int gap);
        exp_t x;
        for (int i = 0; i < 8; i++) begin
            x.b    = msb ? d[7-i] : d[i];
            x.last = (i == 7);
            x.gap  = (i == 0) ? first_gap : gap;
            q.push_back(x);
        end
    endtask

    task automatic put(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge Clk);
        while (!Din_rdy && t < 200) begin
            @(negedge Clk);
            t++;
        end
        chk("put_rdy_timeout", {31'b0, Din_rdy}, 32'd1);
        Din     = d;
        Din_vld = 1'b1;
        @(negedge Clk);
        Din_vld = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge Clk);
            t++;
        end
        chk("drain_timeout", q.size(), 32'd0);
        @(negedge Clk);
        chk("busy_after_drain", {31'b0, Busy}, 32'd0);
    endtask

    task automatic wait_strobes(input int target);
        int t;
        t = 0;
        while (n_stb < target && t < 500) begin
            @(negedge Clk);
            t++;
        end
        chk("strobe_wait_timeout", {31'b0, (n_stb >= target)}, 32'd1);
    endtask

    // Monitor: every strobe must match the head of the scoreboard queue.
    always @(negedge Clk) begin
        cyc_since++;
        if (Word_done && !Bit_stb) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_done_no_strobe: Word_done=1 while Bit_stb=0 (t=%0t)", $time);
        end
        if (Bit_stb) begin
            n_stb++;
            if (Word_done) n_wd++;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_strobe: got Sout=%0b, expected no strobe (t=%0t)",
                         Sout, $time);
            end else begin
                e = q.pop_front();
                chk("strobe_done_bit", {30'b0, Word_done, Sout}, {30'b0, e.last, e.b});
                if (e.gap != 0) chk("strobe_gap", cyc_since, e.gap);
            end
            cyc_since = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] stall_tab [11];
    logic       rdy_tab   [11];
    int         base;
    int         wd0;

    initial begin
        stall_tab = '{8'h3C, 8'hFF, 8'h81, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h5A};
        rdy_tab   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset values
        #12;
        chk("rst_din_rdy", {31'b0, Din_rdy}, 32'd1);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_outs", {29'b0, Sout, Bit_stb, Word_done}, 32'd0);
        @(posedge Clk);
        #2 Rst = 1'b1;

        // Single word A5, MSB first, Div=0, with latency check
        Div = 4'd0;
        Msb_first = 1'b1;
        push_word(8'hA5, 1'b1, 0, 1);
        @(negedge Clk);
        Din = 8'hA5;
        Din_vld = 1'b1;
        @(negedge Clk);
        Din_vld = 1'b0;
        chk("lat_after_accept", {31'b0, Bit_stb}, 32'd0);
        @(negedge Clk);
        chk("lat_first_strobe", {31'b0, Bit_stb}, 32'd1);
        drain();

        // Back-to-back 0A, A0: gapless 16 strobes
        wd0 = n_wd;
        push_word(8'h0A, 1'b1, 0, 1);
        push_word(8'hA0, 1'b1, 1, 1);
        put(8'h0A);
        put(8'hA0);
        chk("b2b_rdy_held", {31'b0, Din_rdy}, 32'd0);
        chk("b2b_busy_held", {31'b0, Busy}, 32'd1);
        drain();
        chk("b2b_word_done_cnt", n_wd - wd0, 32'd2);

        // Divider and order: Div=3 LSB first, new settings only at next transfer
        base = n_stb;
        Div = 4'd3;
        Msb_first = 1'b0;
        push_word(8'h01, 1'b0, 0, 4);
        push_word(8'hC3, 1'b1, 1, 1);
        put(8'h01);
        wait_strobes(base + 2);
        Div = 4'd0;
        Msb_first = 1'b1;
        put(8'hC3);
        drain();

        // Reset mid-word discards shifter and holding register
        wd0 = n_wd;
        base = n_stb;
        push_word(8'hFF, 1'b1, 0, 1);
        push_word(8'h55, 1'b1, 1, 1);
        put(8'hFF);
        put(8'h55);
        wait_strobes(base + 3);
        @(posedge Clk);
        #2 Rst = 1'b0;
        q.delete();
        #1;
        chk("rst_mid_sout_stb_wd", {29'b0, Sout, Bit_stb, Word_done}, 32'd0);
        chk("rst_mid_busy", {31'b0, Busy}, 32'd0);
        chk("rst_mid_din_rdy", {31'b0, Din_rdy}, 32'd1);
        repeat (2) @(negedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        chk("rst_mid_no_word_done", n_wd - wd0, 32'd0);
        push_word(8'h0F, 1'b1, 0, 1);
        put(8'h0F);
        drain();

        // Stall: Din_vld stays high, only accept-edge values are serialized
        push_word(8'h3C, 1'b1, 0, 1);
        push_word(8'h81, 1'b1, 1, 1);
        push_word(8'h5A, 1'b1, 1, 1);
        for (int k = 0; k < 11; k++) begin
            @(negedge Clk);
            Din = stall_tab[k];
            Din_vld = 1'b1;
            #1 chk($sformatf("stall_rdy_c%0d", k), {31'b0, Din_rdy}, {31'b0, rdy_tab[k]});
        end
        @(negedge Clk);
        Din_vld = 1'b0;
        Din = 8'hEE;
        drain();

        chk("queue_empty_end", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001 Parameter DATA_W, default 8: word width in bits, legal range 2..32.
REQ-002 Parameter DIV_W, default 4: width of the bit-period divider input.
REQ-003 Clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 Din  input  DATA_W  parallel word to serialize.
REQ-006 Din_vld  input  1  Din is valid.
REQ-007 Din_rdy  output  1  holding register empty; a word is accepted on a rising edge where Din_vld=1 and Din_rdy=1.
REQ-008 Msb_first  input  1  bit order: 1 = MSB first, 0 = LSB first.
REQ-009 Div  input  DIV_W  bit period minus one, in Clk cycles.
REQ-010 Sout  output  1  serial bit; this is the sequence-detector input stream.
REQ-011 Bit_stb  output  1  single-cycle strobe; Sout is a valid bit in this cycle.
REQ-012 Word_done  output  1  single-cycle pulse coincident with the Bit_stb of a word's last bit.
REQ-013 Busy  output  1  word in shifter or holding register.

Function
REQ-014 Datapath: one holding register (hold, hold_full flag) plus a shift register with bit counter, divider counter and latched bit order and period.
REQ-015 Din_rdy SHALL equal NOT hold_full, decoded from registers only, with no combinational path from any input.
REQ-016 An accept SHALL capture Din into hold and set hold_full; Din_vld while Din_rdy=0 SHALL be ignored and hold SHALL be unchanged.
REQ-017 FSM states: IDLE (shifter empty) and SHIFT.
REQ-018 IDLE with hold_full=1: on the next edge, transfer hold to the shifter, clear hold_full, latch Msb_first and Div, set bit_cnt=0, load div_cnt with Div, go to SHIFT.
REQ-019 IDLE with hold_full=0: remain in IDLE.
REQ-020 In SHIFT, Bit_stb SHALL be 1 exactly when div_cnt=0; otherwise div_cnt decrements by 1 each edge.
REQ-021 Sout SHALL present the current bit for the whole bit period: shifter[DATA_W-1-bit_cnt] if MSB-first, shifter[bit_cnt] otherwise.
REQ-022 On a Bit_stb edge with bit_cnt<DATA_W-1: bit_cnt increments and div_cnt reloads from the latched period.
REQ-023 On a Bit_stb edge with bit_cnt=DATA_W-1, Word_done=1 in that cycle, then:
- if hold_full=1, reload as in REQ-018 with no idle cycle between words;
- otherwise go to IDLE.
REQ-024 Din and Div changes mid-word SHALL NOT affect the word in flight; new Div and Msb_first values take effect at the next transfer.
REQ-025 Accept and transfer can never occur on the same edge, because Din_rdy=0 while hold_full=1; Din_rdy returns to 1 in the cycle after a transfer.
REQ-026 Latency with Div=0: accept on edge E0, transfer on E1, first Bit_stb in the cycle following E1; bit period is Div+1 cycles.
REQ-027 In IDLE: Sout=0, Bit_stb=0, Word_done=0.
REQ-028 Busy SHALL equal (state==SHIFT) OR hold_full.

Reset
REQ-029 While Rst=0, all outputs SHALL immediately take these values regardless of Clk: Sout=0, Bit_stb=0, Word_done=0, Busy=0, Din_rdy=1, state=IDLE, all counters 0, hold_full=0.
REQ-030 Reset mid-word SHALL discard the partial word and any held word, with no Word_done.
REQ-031 The first accept after reset release SHALL serialize from bit 0.

Verification
REQ-032 Reset: drive Rst low mid-operation -> Sout=0, Bit_stb=0, Busy=0, Word_done=0, Din_rdy=1 within the same cycle.
REQ-033 Single word: Div=0, Msb_first=1, Din=8'hA5 ->
- 8 consecutive strobes carrying 1,0,1,0,0,1,0,1;
- first strobe 2 cycles after the accept edge;
- Word_done on the 8th strobe; Busy low afterwards.
REQ-034 Back-to-back: 8'h0A then 8'hA0, Div=0, MSB-first ->
- 16 gapless strobes carrying 0000101010100000;
- Word_done twice;
- Din_rdy=0 while the second word is held.
REQ-035 Divider and order: Div=3, Msb_first=0, Din=8'h01; change Div to 0 after the 2nd strobe ->
- strobes every 4 cycles for all 8 bits, carrying 1 then seven 0s;
- the next word uses a 1-cycle period.
REQ-036 Reset mid-word: Din=8'hFF, Rst low after the 3rd strobe ->
- no Word_done;
- after release, Din=8'h0F serializes 00001111 in full.
REQ-037 Stall: Din_vld held high while Din_rdy=0 with Din changing every cycle -> only values present on accept edges appear on Sout.
